store_merge_unit: RTL and testbench
===================================

# store_merge_unit

Sub-word store engine between the MEM stage and the single-port data block RAM: the write-side counterpart to the immediate/load extenders, narrowing a 32-bit register value into a byte or halfword lane. The RAM has no byte enables, so `sb`/`sh` run as a read-modify-write sequence while the pipeline is stalled. `sw` is a single write. Misaligned stores raise an address-error pulse for the CP0 exception logic.

## Interface
- `ADDR_W`, default 12: word-address width of the data RAM.
- `clk` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `req_valid` input 1: store request from MEM stage.
- `req_ready` output 1: high only in IDLE; a request is accepted when `req_valid && req_ready` at a rising edge.
- `req_op` input 2: 00 `sw`, 01 `sh`, 10 `sb`, 11 reserved (treated as `sw`).
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data; `sb` uses [7:0], `sh` uses [15:0].
- `done` output 1: one-cycle pulse in the cycle `mem_we` is asserted.
- `addr_err` output 1: one-cycle pulse on a misaligned store; no write occurs.
- `mem_addr` output ADDR_W: word address, `req_addr[ADDR_W+1:2]`, registered.
- `mem_re` output 1: RAM read strobe.
- `mem_rdata` input 32: RAM read data, valid the cycle after `mem_re`.
- `mem_we` output 1: RAM write strobe.
- `mem_wdata` output 32: merged word.

## Operation
- States: IDLE, READ, CAPT, WRITE, ERR.
- Accepting a request latches op, lane `addr[1:0]`, word address and data.
- Misalignment check: `sh` with addr[0]=1, or `sw` with addr[1:0]≠0. A misaligned request goes IDLE→ERR, pulses `addr_err` for one cycle, then returns to IDLE. No memory strobes are issued.
- `sw` path: IDLE→WRITE. `mem_wdata` = data and `mem_we` = 1 for one cycle, then IDLE.
- `sb`/`sh` path: IDLE→READ (`mem_re`=1) → CAPT (register `mem_rdata`) → WRITE → IDLE.
- Merge rule: `mem_wdata = (old & ~mask) | ((data << 8*lane) & mask)`.
  - `sb`: mask = 0xFF << 8*addr[1:0].
  - `sh`: mask = 0xFFFF << 16*addr[1].
- `req_ready` = (state==IDLE). A new request can be accepted in the cycle after WRITE or ERR.
- This block is the only writer of the data RAM.

## Timing
- Reset values: state IDLE; `req_ready`=1; `done`, `addr_err`, `mem_re`, `mem_we` = 0; `mem_addr`, `mem_wdata` = 0.
- All outputs except `req_ready` are registered.
- Accept at edge T:
  - `sw`: `mem_we` and `done` high in cycle T+1.
  - `sb`/`sh`: `mem_re` in T+1, capture in T+2, `mem_we` and `done` in T+3.
  - Misaligned: `addr_err` in T+1.
- Request inputs are ignored while `req_ready`=0; the MEM stage holds the pipeline on `!req_ready`.
- Reset asserted mid-sequence: return to IDLE immediately and abandon the write (no `mem_we`). RAM contents are not restored. The forwarding buffer is cleared.
- `mem_addr` is held stable from READ through WRITE.

## Configuration
- `SMU_FWD_EN` defined:
  - A one-entry buffer holds {valid, word address, last written word}.
  - An `sb`/`sh` request that hits a valid entry goes IDLE→WRITE and merges into the buffered word. Latency drops to `sw` latency (done at T+1) and no `mem_re` is issued.
  - Every write updates the buffer. Reset clears `valid`.
- `SMU_FWD_EN` undefined: no buffer; every `sb`/`sh` performs the full read-modify-write.

## Test plan
- Reset: hold `reset`=0 for 3 cycles -> `req_ready`=1 and all strobes 0; release -> still IDLE.
- `sw` addr 0x10, data 0xDEADBEEF -> `mem_we`/`done` at T+1, `mem_addr`=4, `mem_wdata`=0xDEADBEEF; `req_ready` low for exactly one cycle.
- RAM word 4 = 0x11223344; `sb` addr 0x12, data 0x000000AB -> `mem_re` at T+1, write at T+3 with 0x11AB3344. Then `sh` addr 0x12, data 0x5566 -> 0x55663344.
- `sh` addr 0x13 -> `addr_err` at T+1, no `mem_re`/`mem_we`. `sw` addr 0x16 -> `addr_err` at T+1, no strobes.
- Assert `reset` in the CAPT cycle of an `sb` -> no `mem_we` ever issued, RAM word unchanged, IDLE next cycle.
- With `SMU_FWD_EN`:
  - `sw` 0x20 = 0xCAFEF00D, then `sb` 0x20 data 0x77 -> `done` at T+1, no `mem_re`, `mem_wdata`=0xCAFEF077.
  - Without the macro -> same data, `done` at T+3.

Source files
------------

// File: rtl/store_merge_unit.sv
// Sub-word store engine: sb/sh become read-modify-write on a data RAM without byte enables.
// Optional macro SMU_FWD_EN adds a one-entry last-write buffer so sb/sh hits skip the RAM read.
module store_merge_unit #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              done,
  output logic              addr_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_wdata
);
  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] CAPT  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] ERR   = 3'd4;

  localparam logic [1:0] OP_SH = 2'b01;
  localparam logic [1:0] OP_SB = 2'b10;

  logic [2:0]        state, state_nx;
  logic              op_byte_q;
  logic [1:0]        lane_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] wdata_nx;
  logic [ADDR_W-1:0] req_word, word_nx;
  logic              accept, req_sub, req_byte, misaligned;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_word;
  logic              unused_addr_bits;

  assign req_word         = req_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^req_addr[DATA_W-1:ADDR_W+2];
  assign req_ready        = (state == IDLE);
  assign accept           = req_valid && req_ready;
  assign req_byte         = (req_op == OP_SB);
  assign req_sub          = (req_op == OP_SB) || (req_op == OP_SH);
  // Reserved op 2'b11 falls into the word-store alignment rule.
  assign misaligned       = ((req_op == OP_SH) && req_addr[0]) ||
                            (!req_sub && (req_addr[1:0] != 2'b00));

  // Replace the selected byte/halfword lane of old with the low bits of src.
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                              input logic [DATA_W-1:0] src,
                                              input logic              is_byte,
                                              input logic [1:0]        ln);
    logic [DATA_W-1:0] mask;
    logic [4:0]        shamt;
    shamt = {ln, 3'b000};
    mask  = is_byte ? (DATA_W'(32'h0000_00FF) << shamt)
                    : (DATA_W'(32'h0000_FFFF) << {ln[1], 4'b0000});
    return (old & ~mask) | ((src << shamt) & mask);
  endfunction

  // Next state plus the word address and merged data to be registered at the coming edge.
  always_comb begin
    state_nx = state;
    wdata_nx = mem_wdata;
    word_nx  = mem_addr;
    case (state)
      IDLE: begin
        if (req_valid) begin
          word_nx = req_word;
          if (misaligned) begin
            state_nx = ERR;
          end else if (!req_sub) begin
            state_nx = WRITE;
            wdata_nx = req_wdata;
          end else if (fwd_hit) begin
            state_nx = WRITE;
            wdata_nx = merge(fwd_word, req_wdata, req_byte, req_addr[1:0]);
          end else begin
            state_nx = READ;
          end
        end
      end
      READ:  state_nx = CAPT;
      CAPT: begin
        state_nx = WRITE;
        wdata_nx = merge(mem_rdata, data_q, op_byte_q, lane_q);
      end
      WRITE: state_nx = IDLE;
      ERR:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      op_byte_q <= 1'b0;
      lane_q    <= 2'b00;
      data_q    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      done      <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      state     <= state_nx;
      mem_re    <= (state_nx == READ);
      mem_we    <= (state_nx == WRITE);
      done      <= (state_nx == WRITE);
      addr_err  <= (state_nx == ERR);
      mem_addr  <= word_nx;
      mem_wdata <= wdata_nx;
      if (accept) begin
        op_byte_q <= req_byte;
        lane_q    <= req_addr[1:0];
        data_q    <= req_wdata;
      end
    end
  end

`ifdef SMU_FWD_EN
  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_addr;

  // Mirrors the word being written so a following sub-word store to it needs no RAM read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwd_valid <= 1'b0;
      fwd_addr  <= '0;
      fwd_word  <= '0;
    end else if (state_nx == WRITE) begin
      fwd_valid <= 1'b1;
      fwd_addr  <= word_nx;
      fwd_word  <= wdata_nx;
    end
  end

  assign fwd_hit = fwd_valid && (fwd_addr == req_word);
`else
  assign fwd_hit  = 1'b0;
  assign fwd_word = '0;
`endif

endmodule

// File: tb/tb_store_merge_unit.sv
// Self-checking bench for store_merge_unit: RAM model, bench-side memory/forwarding model, scoreboard.
module tb_store_merge_unit;
`ifdef SMU_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    bit          is_err;
    logic [11:0] addr;
    logic [31:0] data;
    int          cyc;
    int          re_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        done, addr_err, mem_re, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] mem_wdata;

  logic [31:0] ram [0:4095];
  logic [31:0] model_mem [0:4095];
  logic [31:0] rd = '0;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  bit          fwd_v = 1'b0;
  int          fwd_a = 0;
  exp_t        sb_q [$];

  store_merge_unit #(.ADDR_W(12)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done), .addr_err(addr_err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] seed_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  // Data RAM: registered read, data valid the cycle after mem_re.
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 4096; i++) ram[i] <= seed_word(i);
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_re) rd <= ram[mem_addr];
    end
    cyc <= cyc + 1;
  end
  assign mem_rdata = rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every strobe is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (mem_re) begin
      if (sb_q.size() == 0) check_eq("re_unexpected", 32'(mem_re), 32'd0);
      else begin
        check_eq("re_cycle", 32'(cyc), 32'(sb_q[0].re_cyc));
        check_eq("re_addr", 32'(mem_addr), 32'(sb_q[0].addr));
      end
    end
    if (mem_we || addr_err) begin
      if (sb_q.size() == 0) check_eq("strobe_unexpected", {30'd0, mem_we, addr_err}, 32'd0);
      else begin
        e = sb_q.pop_front();
        check_eq("strobe_kind", {30'd0, mem_we, addr_err}, e.is_err ? 32'd1 : 32'd2);
        check_eq("strobe_cycle", 32'(cyc), 32'(e.cyc));
        if (!e.is_err) begin
          check_eq("we_addr", 32'(mem_addr), 32'(e.addr));
          check_eq("we_data", mem_wdata, e.data);
        end
      end
    end
    if (mem_we || done) check_eq("done_with_we", 32'(done), 32'(mem_we));
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
    exp_t        e;
    int          waits, acc, w, ln;
    logic [31:0] nw;
    bit          sub, mis, hit;
    waits = 0;
    @(negedge clk);
    while (!req_ready && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 40) check_eq("ready_timeout", 32'(req_ready), 32'd1);
    acc = cyc + 1;
    w   = int'(addr[13:2]);
    ln  = int'(addr[1:0]);
    sub = (op == 2'b01) || (op == 2'b10);
    mis = (op == 2'b01 && addr[0]) || (!sub && addr[1:0] != 2'b00);
    e.is_err = mis;
    e.addr   = addr[13:2];
    e.data   = '0;
    e.cyc    = acc;
    e.re_cyc = -1;
    if (!mis) begin
      nw = model_mem[w];
      if (op == 2'b10) nw[8*ln +: 8] = data[7:0];
      else if (op == 2'b01) nw[16*(ln/2) +: 16] = data[15:0];
      else nw = data;
      hit = FWD && fwd_v && (fwd_a == w);
      if (sub && !hit) begin
        e.cyc    = acc + 2;
        e.re_cyc = acc;
      end
      e.data       = nw;
      model_mem[w] = nw;
      fwd_v        = 1'b1;
      fwd_a        = w;
    end
    sb_q.push_back(e);
    req_op    = op;
    req_addr  = addr;
    req_wdata = data;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] saved;
    for (int i = 0; i < 4096; i++) model_mem[i] = seed_word(i);

    // Reset held for three cycles: idle, no strobes.
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_ready", 32'(req_ready), 32'd1);
      check_eq("rst_strobes", {28'd0, mem_re, mem_we, done, addr_err}, 32'd0);
      check_eq("rst_addr", 32'(mem_addr), 32'd0);
      check_eq("rst_wdata", mem_wdata, 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", 32'(req_ready), 32'd1);

    // Word store: write at T+1 and ready low for exactly one cycle.
    issue(2'b00, 32'h10, 32'hDEAD_BEEF);
    @(negedge clk);
    check_eq("sw_ready_low", 32'(req_ready), 32'd0);
    @(negedge clk);
    check_eq("sw_ready_back", 32'(req_ready), 32'd1);
    drain();

    // Byte then halfword merge into word 4.
    issue(2'b00, 32'h10, 32'h1122_3344);
    issue(2'b10, 32'h12, 32'h0000_00AB);
    issue(2'b01, 32'h12, 32'h0000_5566);
    drain();

    // Misaligned stores, including reserved op as a word store.
    issue(2'b01, 32'h13, 32'h0000_1234);
    issue(2'b00, 32'h16, 32'h0BAD_0BAD);
    issue(2'b11, 32'h15, 32'h0BAD_0BAD);
    issue(2'b11, 32'h18, 32'h7777_8888);
    drain();

    // Byte store right after a word store to the same word.
    issue(2'b00, 32'h20, 32'hCAFE_F00D);
    issue(2'b10, 32'h20, 32'h0000_0077);
    drain();

    // Mixed random traffic over a small address window.
    for (int i = 0; i < 30; i++) begin
      issue(2'($urandom_range(0, 3)), {18'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))} , $urandom);
    end
    drain();
    issue(2'b00, 32'h20, 32'h0102_0304);
    drain();

    // Reset during CAPT of a byte store to an unbuffered word abandons the write.
    saved = model_mem[40];
    issue(2'b10, 32'hA1, 32'h0000_005A);
    @(negedge clk);
    @(negedge clk);
    check_eq("capt_no_we", 32'(mem_we), 32'd0);
    #1;
    reset = 1'b0;
    sb_q.delete();
    model_mem[40] = saved;
    fwd_v = 1'b0;
    #1;
    check_eq("midrst_ready", 32'(req_ready), 32'd1);
    check_eq("midrst_we", 32'(mem_we), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check_eq("midrst_no_we", 32'(mem_we), 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_ram", ram[40], saved);
    check_eq("midrst_idle", 32'(req_ready), 32'd1);

    // After reset the buffered word must be re-read from RAM.
    issue(2'b10, 32'h21, 32'h0000_00C3);
    issue(2'b10, 32'hA1, 32'h0000_005A);
    drain();

    @(negedge clk);
    for (int i = 0; i < 48; i++) check_eq("ram_final", ram[i], model_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
